// File: rtl/alu_mw_seq.sv
// Multi-word execute sequencer that sits upstream of the 16-bit ALU.
// It runs one ALU pass per word, least-significant word first, chains carry between passes, and owns the {Z,CY,S,P,OV} flag register.
module alu_mw_seq #(
  parameter int unsigned WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic                  use_cy,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  flg_we,
  input  logic [4:0]            flg_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   result,
  output logic [4:0]            flags,
  output logic [2:0]            alu_opcode,
  output logic [15:0]           alu_arg1,
  output logic [15:0]           alu_arg2,
  output logic [4:0]            alu_in_flg,
  output logic                  alu_block_cy_ov,
  input  logic [15:0]           alu_res,
  input  logic [4:0]            alu_out_flg
);

  localparam int unsigned W    = 16 * WORDS;
  localparam int unsigned IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned F_Z  = 4;
  localparam int unsigned F_CY = 3;
  localparam int unsigned F_S  = 2;
  localparam int unsigned F_P  = 1;
  localparam int unsigned F_OV = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            use_cy_q, use_cy_d;
  logic            cy_q, cy_d;
  logic            zacc_q, zacc_d;
  logic            pacc_q, pacc_d;
  logic [W-1:0]    result_q, result_d;
  logic [4:0]      flags_q, flags_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            last_c;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;
  assign last_c = (idx_q == IW'(WORDS - 1));

  // Present the current word of the latched operands to the ALU.
  always_comb begin
    alu_arg1 = '0;
    alu_arg2 = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (idx_q == IW'(i)) begin
        alu_arg1 = a_q[i*16 +: 16];
        alu_arg2 = b_q[i*16 +: 16];
      end
    end
  end

  assign alu_opcode      = op_q;
  assign alu_block_cy_ov = (op_q != 3'b000) && (op_q != 3'b001);

  // Word 0 takes the optional architectural carry; later words take the chained carry.
  always_comb begin
    alu_in_flg       = flags_q;
    alu_in_flg[F_CY] = (idx_q == '0) ? (use_cy_q & flags_q[F_CY]) : cy_q;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    use_cy_d = use_cy_q;
    cy_d     = cy_q;
    zacc_d   = zacc_q;
    pacc_d   = pacc_q;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          use_cy_d = use_cy;
          idx_d    = '0;
          zacc_d   = 1'b1;
          pacc_d   = 1'b0;
          state_d  = S_EXEC;
        end else if (flg_we) begin
          flags_d = flg_wdata;
        end
      end
      S_EXEC: begin
        for (int i = 0; i < int'(WORDS); i++) begin
          if (idx_q == IW'(i)) begin
            result_d[i*16 +: 16] = alu_res;
          end
        end
        cy_d   = alu_out_flg[F_CY];
        zacc_d = zacc_q & alu_out_flg[F_Z];
        pacc_d = pacc_q ^ alu_out_flg[F_P];
        if (last_c) begin
          // Whole-operand flags: Z and P fold every word, the rest come from the top word.
          flags_d[F_Z]  = zacc_q & alu_out_flg[F_Z];
          flags_d[F_CY] = alu_out_flg[F_CY];
          flags_d[F_S]  = alu_out_flg[F_S];
          flags_d[F_P]  = pacc_q ^ alu_out_flg[F_P];
          flags_d[F_OV] = alu_out_flg[F_OV];
          idx_d         = '0;
          state_d       = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_EXEC);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      use_cy_q <= 1'b0;
      cy_q     <= 1'b0;
      zacc_q   <= 1'b0;
      pacc_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      use_cy_q <= use_cy_d;
      cy_q     <= cy_d;
      zacc_q   <= zacc_d;
      pacc_q   <= pacc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule
